// File: rtl/adc_stream_source.sv
// adc_stream_source
// Captures free-running ADC I/Q sample pairs (no backpressure), sign-extends
// each rail to 16 bits, packs them as {Q, I} into 32-bit words and buffers the
// words in a show-ahead FIFO. The FIFO is presented as a valid/ready stream
// with optional frame "last" marking. Samples arriving while the FIFO is full
// (and not draining that cycle) are dropped and counted.
module adc_stream_source #(
  parameter int ADC_W     = 12,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic [ADC_W-1:0]         i_adc_i,
  input  logic [ADC_W-1:0]         i_adc_q,
  input  logic                     i_adc_valid,
  output logic [31:0]              o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic [15:0]              o_ovf_count,
  output logic                     o_ovf_sticky,
  input  logic                     i_ovf_clear
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((FRAME_LEN > 0) ? (FRAME_LEN - 1) : 0);
  localparam logic              FRAME_EN = (FRAME_LEN > 0);

  // Sign-extend one ADC rail to 16 bits; a 16-bit rail passes through unchanged.
  function automatic logic [15:0] sext16(input logic [ADC_W-1:0] x);
    return 16'($signed(x));
  endfunction

  // Storage and state
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_next_s;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [31:0]       head_q, head_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic              ovf_sticky_q, ovf_sticky_d;

  // Per-cycle handshake terms
  logic [31:0]       word_s;
  logic              full_s;
  logic              empty_after_pop_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;

  // Handshake decode: pop when the head is taken, push when there is room or a same-cycle pop frees a slot.
  always_comb begin
    word_s            = {sext16(i_adc_q), sext16(i_adc_i)};
    full_s            = (fill_q == FULL_LVL);
    pop_s             = valid_q & i_ready;
    push_s            = i_adc_valid & i_enable & (~full_s | pop_s);
    drop_s            = i_adc_valid & i_enable & full_s & ~pop_s;
    empty_after_pop_s = (fill_q == {FILL_W{1'b0}}) |
                        (pop_s & (fill_q == FILL_W'(1)));
  end

  // FIFO bookkeeping: pointers wrap naturally, occupancy is tracked on its own so full/empty never alias.
  always_comb begin
    rd_next_s = rd_ptr_q + 1'b1;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_next_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s && !pop_s) begin
      fill_d = fill_q + 1'b1;
    end else if (pop_s && !push_s) begin
      fill_d = fill_q - 1'b1;
    end else begin
      fill_d = fill_q;
    end

    valid_d = (fill_d != {FILL_W{1'b0}});
  end

  // Head register: a word entering an empty FIFO bypasses memory so it is visible right after its push edge.
  always_comb begin
    if (empty_after_pop_s) begin
      if (push_s) begin
        head_d = word_s;
      end else begin
        head_d = head_q;
      end
    end else if (pop_s) begin
      head_d = mem_q[rd_next_s];
    end else begin
      head_d = head_q;
    end
  end

  // Frame counter: counts popped words, wraps on the frame's final word; o_last reflects the new head.
  always_comb begin
    if (pop_s) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = {CNT_W{1'b0}};
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    last_d = FRAME_EN & valid_d & (frame_cnt_d == CNT_LAST);
  end

  // Drop accounting: clear wins over a same-cycle drop; the count saturates at all-ones.
  always_comb begin
    if (i_ovf_clear) begin
      ovf_cnt_d    = 16'h0000;
      ovf_sticky_d = 1'b0;
    end else if (drop_s) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_q == 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q;
      end else begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end else begin
      ovf_cnt_d    = ovf_cnt_q;
      ovf_sticky_d = ovf_sticky_q;
    end
  end

  // FIFO storage write; contents are don't-care after reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= word_s;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      fill_q       <= {FILL_W{1'b0}};
      head_q       <= 32'h0000_0000;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_cnt_q  <= {CNT_W{1'b0}};
      ovf_cnt_q    <= 16'h0000;
      ovf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign o_data       = head_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_fill       = fill_q;
  assign o_ovf_count  = ovf_cnt_q;
  assign o_ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_adc_stream_source.sv
// Scoreboard bench for adc_stream_source (ADC_W=12, DEPTH=16, FRAME_LEN=4).
// Stimulus pushes expected words into a queue; a negedge monitor pops and
// compares every word the DUT hands over, including its o_last position.
module tb_adc_stream_source;

  logic        clk;
  logic        reset;
  logic        i_enable;
  logic [11:0] i_adc_i;
  logic [11:0] i_adc_q;
  logic        i_adc_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic [4:0]  o_fill;
  logic [15:0] o_ovf_count;
  logic        o_ovf_sticky;
  logic        i_ovf_clear;

  int tests_run = 0;
  int fails     = 0;
  int frame_idx = 0;
  int last_seen = 0;
  logic [31:0] sb_q[$];

  adc_stream_source #(.ADC_W(12), .DEPTH(16), .FRAME_LEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_adc_i      (i_adc_i),
    .i_adc_q      (i_adc_q),
    .i_adc_valid  (i_adc_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_fill       (o_fill),
    .o_ovf_count  (o_ovf_count),
    .o_ovf_sticky (o_ovf_sticky),
    .i_ovf_clear  (i_ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] si(input int k);
    return 12'(k * 291 + 5);
  endfunction

  function automatic logic [11:0] sq(input int k);
    return ~12'(k * 157);
  endfunction

  function automatic logic [31:0] exp_word(input logic [11:0] iv, input logic [11:0] qv);
    return {{4{qv[11]}}, qv, {4{iv[11]}}, iv};
  endfunction

  // Monitor: every handshake pops one expected word and checks data and frame position.
  always @(negedge clk) begin
    if (reset) begin
      frame_idx = 0;
    end else if (o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        fails++;
        tests_run++;
        $display("FAIL unexpected_word: got %h expected none", o_data);
      end else begin
        check("sb_data", o_data, sb_q.pop_front());
      end
      check("sb_last", {31'd0, o_last}, {31'd0, (frame_idx == 3)});
      if (o_last) last_seen++;
      frame_idx = (frame_idx == 3) ? 0 : frame_idx + 1;
    end
  end

  // Drive n back-to-back samples starting at index base; the first n_exp are expected to be accepted.
  task automatic send_burst(input int n, input int base, input int n_exp);
    for (int k = 0; k < n; k++) begin
      i_adc_i     = si(base + k);
      i_adc_q     = sq(base + k);
      i_adc_valid = 1'b1;
      if (k < n_exp) sb_q.push_back(exp_word(si(base + k), sq(base + k)));
      @(posedge clk); #1;
    end
    i_adc_valid = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int c = 0; c < 100 && o_fill != 5'd0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_fill", {27'd0, o_fill}, 32'd0);
    check("drain_valid", {31'd0, o_valid}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0; i_enable = 1'b1; i_adc_i = 12'h000; i_adc_q = 12'h000;
    i_adc_valid = 1'b0; i_ready = 1'b1; i_ovf_clear = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    check("rst_fill", {27'd0, o_fill}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_cnt", {16'd0, o_ovf_count}, 32'd0);
    check("rst_sticky", {31'd0, o_ovf_sticky}, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: single sample, one-cycle latency, valid for one clock
    i_adc_i = 12'h800; i_adc_q = 12'h7FF; i_adc_valid = 1'b1;
    sb_q.push_back(32'h07FF_F800);
    @(posedge clk); #1 i_adc_valid = 1'b0;
    check("t1_valid", {31'd0, o_valid}, 32'd1);
    check("t1_data", o_data, 32'h07FF_F800);
    check("t1_fill", {27'd0, o_fill}, 32'd1);
    @(posedge clk); #1;
    check("t1_valid_off", {31'd0, o_valid}, 32'd0);

    // 2: stalled sink, 20 samples: 16 stored, 4 dropped
    i_ready = 1'b0;
    send_burst(20, 100, 16);
    check("t2_fill", {27'd0, o_fill}, 32'd16);
    check("t2_cnt", {16'd0, o_ovf_count}, 32'd4);
    check("t2_sticky", {31'd0, o_ovf_sticky}, 32'd1);
    drain();

    // 3: full FIFO with draining sink accepts every sample, fill stays 16
    i_ready = 1'b0;
    send_burst(16, 200, 16);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_adc_i = si(300 + k); i_adc_q = sq(300 + k); i_adc_valid = 1'b1;
      sb_q.push_back(exp_word(si(300 + k), sq(300 + k)));
      @(posedge clk); #1;
      check("t3_fill", {27'd0, o_fill}, 32'd16);
    end
    i_adc_valid = 1'b0;
    check("t3_cnt", {16'd0, o_ovf_count}, 32'd4);
    drain();

    // Clear the drop counter
    i_ovf_clear = 1'b1;
    @(posedge clk); #1 i_ovf_clear = 1'b0;
    check("clr_cnt", {16'd0, o_ovf_count}, 32'd0);
    check("clr_sticky", {31'd0, o_ovf_sticky}, 32'd0);

    // 5: reset with fill=9, count=3
    i_ready = 1'b0;
    send_burst(19, 400, 16);
    i_ready = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    i_ready = 1'b0;
    check("t5_fill_pre", {27'd0, o_fill}, 32'd9);
    check("t5_cnt_pre", {16'd0, o_ovf_count}, 32'd3);
    #3 reset = 1'b1;
    #1;
    check("t5_valid", {31'd0, o_valid}, 32'd0);
    check("t5_last", {31'd0, o_last}, 32'd0);
    check("t5_fill", {27'd0, o_fill}, 32'd0);
    check("t5_data", o_data, 32'd0);
    check("t5_cnt", {16'd0, o_ovf_count}, 32'd0);
    check("t5_sticky", {31'd0, o_ovf_sticky}, 32'd0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    i_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t5_post_valid", {31'd0, o_valid}, 32'd0);
    check("t5_post_fill", {27'd0, o_fill}, 32'd0);

    // 4: FRAME_LEN=4, 10 words -> last on words 3 and 7; two more words end a frame
    begin
      int lc0;
      lc0 = last_seen;
      send_burst(10, 500, 10);
      drain();
      check("t4_lasts10", last_seen - lc0, 32'd2);
      send_burst(2, 520, 2);
      drain();
      check("t4_lasts12", last_seen - lc0, 32'd3);
    end

    // i_enable=0: samples ignored while empty
    i_enable = 1'b0; i_adc_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    i_adc_valid = 1'b0;
    check("en0_fill", {27'd0, o_fill}, 32'd0);
    check("en0_valid", {31'd0, o_valid}, 32'd0);
    i_enable = 1'b1;

    // 6: saturation and clear priority; disabled samples at full are not drops
    i_ready = 1'b0;
    send_burst(16, 600, 16);
    i_enable = 1'b0; i_adc_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("en0_full_cnt", {16'd0, o_ovf_count}, 32'd0);
    check("en0_full_sticky", {31'd0, o_ovf_sticky}, 32'd0);
    check("en0_full_fill", {27'd0, o_fill}, 32'd16);
    i_enable = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("t6_cnt_max", {16'd0, o_ovf_count}, 32'h0000_FFFF);
    check("t6_sticky", {31'd0, o_ovf_sticky}, 32'd1);
    @(posedge clk); #1;
    check("t6_cnt_sat", {16'd0, o_ovf_count}, 32'h0000_FFFF);
    i_ovf_clear = 1'b1;
    @(posedge clk); #1;
    i_ovf_clear = 1'b0; i_adc_valid = 1'b0;
    check("t6_clr_cnt", {16'd0, o_ovf_count}, 32'd0);
    check("t6_clr_sticky", {31'd0, o_ovf_sticky}, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
